// File: rtl/display_pkg.sv
// Shared types and constants for the monitor display.
// Segment table, converter FSM encoding, helpers.
package display_pkg;

  localparam int DW       = 8;
  localparam int BW       = 12;
  localparam int DD_ITERS = 8;
  localparam int IW       = $clog2(DD_ITERS);

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } dd_state_e;

  // Active-low {dp,g,f,e,d,c,b,a}; entry 0 is the rightmost.
  localparam logic [15:0][7:0] SEG_HEX = {
    8'h8E, 8'h86, 8'hA1, 8'hC6,
    8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99,
    8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  function automatic logic [3:0] dd_add3(
    input logic [3:0] n
  );
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  function automatic logic [BW-1:0] dd_adjust(
    input logic [BW-1:0] w
  );
    return {dd_add3(w[11:8]),
            dd_add3(w[7:4]),
            dd_add3(w[3:0])};
  endfunction

endpackage

// File: rtl/monitor_display_bin2bcd_seq.sv
// Sequential double-dabble converter with change detect.
// Latches BCD and the matching binary value together.
module bin2bcd_seq
  import display_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] bin,
  output logic [BW-1:0] bcd,
  output logic [DW-1:0] bin_latched,
  output logic          busy
);

  dd_state_e     state_q;
  logic [DW-1:0] shadow_q;
  logic [DW-1:0] shift_q;
  logic [BW-1:0] work_q;
  logic [IW-1:0] iter_q;
  logic [BW-1:0] bcd_q;
  logic [DW-1:0] lat_q;
  logic          busy_q;
  logic [BW-1:0] adj_d;

  // Add-3 correction applied before every shift.
  always_comb begin
    adj_d = dd_adjust(work_q);
  end

  // Converter FSM: capture on change, 8 shifts, latch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      shadow_q <= '0;
      shift_q  <= '0;
      work_q   <= '0;
      iter_q   <= '0;
      bcd_q    <= '0;
      lat_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (bin != shadow_q) begin
            shift_q  <= bin;
            shadow_q <= bin;
            work_q   <= '0;
            iter_q   <= '0;
            busy_q   <= 1'b1;
            state_q  <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          {work_q, shift_q} <= {adj_d, shift_q} << 1;
          iter_q <= iter_q + 1'b1;
          if (iter_q == IW'(DD_ITERS - 1)) begin
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          bcd_q   <= work_q;
          lat_q   <= shadow_q;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bcd         = bcd_q;
  assign bin_latched = lat_q;
  assign busy        = busy_q;

endmodule

// File: rtl/monitor_display.sv
// 3-digit multiplexed seven-segment display of an 8-bit value.
// Decimal via sequential converter, or 2-digit hex.
module monitor_display
  import display_pkg::*;
#(
  parameter int SCAN_DIV = 50000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] value,
  input  logic          hex_mode,
  input  logic          blank_zero,
  output logic [7:0]    seg,
  output logic [2:0]    an,
  output logic          busy,
  output logic [BW-1:0] bcd
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam logic [PW-1:0] PS_LAST = PW'(SCAN_DIV - 1);

  logic [BW-1:0] bcd_w;
  logic [DW-1:0] disp_bin_w;
  logic          busy_w;

  logic [PW-1:0] presc_q;
  logic [1:0]    idx_q;
  logic [7:0]    seg_q;
  logic [2:0]    an_q;

  logic [3:0]    nib_d;
  logic          blank_d;
  logic [7:0]    seg_d;
  logic [2:0]    an_d;

  logic          hund_z;
  logic          tens_z;
  logic          hi_z;

  bin2bcd_seq u_conv (
    .clk         (clk),
    .rst         (rst),
    .bin         (value),
    .bcd         (bcd_w),
    .bin_latched (disp_bin_w),
    .busy        (busy_w)
  );

  // Slot prescaler and digit index, 0->1->2->0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_q <= '0;
      idx_q   <= 2'd0;
    end else if (presc_q == PS_LAST) begin
      presc_q <= '0;
      idx_q   <= (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
    end else begin
      presc_q <= presc_q + 1'b1;
    end
  end

  assign hund_z = (bcd_w[11:8] == 4'd0);
  assign tens_z = (bcd_w[7:4] == 4'd0);
  assign hi_z   = (disp_bin_w[7:4] == 4'd0);

  // Pick the nibble for the current slot and decide blanking.
  always_comb begin
    nib_d   = 4'd0;
    blank_d = 1'b1;
    unique case (1'b1)
      hex_mode && (idx_q == 2'd0): begin
        nib_d   = disp_bin_w[3:0];
        blank_d = 1'b0;
      end
      hex_mode && (idx_q == 2'd1): begin
        nib_d   = disp_bin_w[7:4];
        blank_d = blank_zero && hi_z;
      end
      !hex_mode && (idx_q == 2'd0): begin
        nib_d   = bcd_w[3:0];
        blank_d = 1'b0;
      end
      !hex_mode && (idx_q == 2'd1): begin
        nib_d   = bcd_w[7:4];
        blank_d = blank_zero && hund_z && tens_z;
      end
      !hex_mode && (idx_q == 2'd2): begin
        nib_d   = bcd_w[11:8];
        blank_d = blank_zero && hund_z;
      end
      default: begin
        nib_d   = 4'd0;
        blank_d = 1'b1;
      end
    endcase
  end

  // Segment pattern and one-hot anode for this slot.
  always_comb begin
    seg_d = blank_d ? SEG_BLANK : SEG_HEX[nib_d];
    an_d  = ~(3'b001 << idx_q);
  end

  // Register the display drive every clock.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seg_q <= SEG_BLANK;
      an_q  <= 3'b111;
    end else begin
      seg_q <= seg_d;
      an_q  <= an_d;
    end
  end

  assign seg  = seg_q;
  assign an   = an_q;
  assign busy = busy_w;
  assign bcd  = bcd_w;

endmodule

// File: tb/tb_monitor_display.sv
// Scoreboard bench for monitor_display.
// Reference model works from decimal arithmetic and slot timing.
module tb_monitor_display;

  localparam int SD = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] value = 8'd0;
  logic       hex_mode = 1'b0;
  logic       blank_zero = 1'b0;
  logic [7:0] seg;
  logic [2:0] an;
  logic       busy;
  logic [11:0] bcd;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  monitor_display #(.SCAN_DIV(SD)) dut (
    .clk        (clk),
    .rst        (rst_n),
    .value      (value),
    .hex_mode   (hex_mode),
    .blank_zero (blank_zero),
    .seg        (seg),
    .an         (an),
    .busy       (busy),
    .bcd        (bcd)
  );

  logic [7:0] SEGT [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  typedef struct {
    logic [7:0] seg;
    logic [2:0] an;
    logic       busy;
    int         edge_n;
  } disp_exp_t;

  typedef struct {
    logic [11:0] bcd;
    int          done;
  } conv_exp_t;

  disp_exp_t dq[$];
  conv_exp_t cq[$];

  int n_edge = 0;
  int shadow_m = 0;
  int disp_m = 0;
  int pend_m = 0;
  int cap_e = -100;

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [7:0] exp_seg(
    input int idx, input int v, input logic hx, input logic bz
  );
    int h, t, o;
    h = v / 100;
    t = (v / 10) % 10;
    o = v % 10;
    if (hx) begin
      if (idx == 0) return SEGT[v % 16];
      if (idx == 1) return (bz && v / 16 == 0) ? 8'hFF : SEGT[v / 16];
      return 8'hFF;
    end
    if (idx == 0) return SEGT[o];
    if (idx == 1) return (bz && h == 0 && t == 0) ? 8'hFF : SEGT[t];
    return (bz && h == 0) ? 8'hFF : SEGT[h];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: sample inputs at each clock, predict outputs.
  initial begin
    disp_exp_t e;
    conv_exp_t c;
    int idx;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        n_edge = 0;
        shadow_m = 0;
        disp_m = 0;
        pend_m = 0;
        cap_e = -100;
        dq.delete();
        cq.delete();
      end else begin
        n_edge++;
        idx = ((n_edge - 1) / SD) % 3;
        e.seg = exp_seg(idx, disp_m, hex_mode, blank_zero);
        e.an = ~3'(1 << idx);
        if (n_edge == cap_e + 9) disp_m = pend_m;
        if (n_edge >= cap_e + 10 && int'(value) != shadow_m) begin
          cap_e = n_edge;
          shadow_m = int'(value);
          pend_m = int'(value);
          c.bcd = to_bcd(int'(value));
          c.done = n_edge + 9;
          cq.push_back(c);
        end
        e.busy = (n_edge >= cap_e) && (n_edge <= cap_e + 8);
        e.edge_n = n_edge;
        dq.push_back(e);
      end
    end
  end

  // Monitor: compare scan outputs each cycle, results on busy fall.
  initial begin
    disp_exp_t e;
    conv_exp_t c;
    bit pb;
    pb = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pb = 1'b0;
      end else begin
        if (dq.size() > 0) begin
          e = dq.pop_front();
          tests++;
          if ({seg, an, busy} !== {e.seg, e.an, e.busy}) begin
            fails++;
            $display("FAIL scan@%0d: seg=%h an=%b busy=%b want seg=%h an=%b busy=%b",
                     e.edge_n, seg, an, busy, e.seg, e.an, e.busy);
          end
        end
        if (pb && !busy) begin
          tests++;
          if (cq.size() == 0) begin
            fails++;
            $display("FAIL conv@%0d: unexpected completion bcd=%h", n_edge, bcd);
          end else begin
            c = cq.pop_front();
            if (bcd !== c.bcd || n_edge != c.done) begin
              fails++;
              $display("FAIL conv: bcd=%h at edge %0d, want %h at edge %0d",
                       bcd, n_edge, c.bcd, c.done);
            end
          end
        end
        pb = busy;
      end
    end
  end

  task automatic check_reset(input string tag);
    chk({tag, "_seg"}, 32'(seg), 32'hFF);
    chk({tag, "_an"}, 32'(an), 32'h7);
    chk({tag, "_busy"}, 32'(busy), 32'h0);
    chk({tag, "_bcd"}, 32'(bcd), 32'h000);
  endtask

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Stimulus.
  initial begin
    rst_n = 1'b0;
    hold(2);
    check_reset("rst0");
    rst_n = 1'b1;
    hold(14);

    value = 8'd255;
    hold(10);
    chk("bcd255", 32'(bcd), 32'h255);
    hold(20);

    blank_zero = 1'b1;
    value = 8'd7;
    hold(30);
    chk("bcd007", 32'(bcd), 32'h007);
    value = 8'd100;
    hold(30);
    chk("bcd100", 32'(bcd), 32'h100);

    hex_mode = 1'b1;
    blank_zero = 1'b0;
    value = 8'hAB;
    hold(30);
    blank_zero = 1'b1;
    value = 8'h0B;
    hold(30);

    hex_mode = 1'b0;
    blank_zero = 1'b0;
    value = 8'd12;
    hold(30);
    value = 8'd200;
    hold(3);
    value = 8'd37;
    hold(7);
    chk("bcd200", 32'(bcd), 32'h200);
    hold(10);
    chk("bcd037", 32'(bcd), 32'h037);
    hold(20);

    value = 8'd99;
    hold(4);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset("rst_mid");
    value = 8'd0;
    hold(2);
    rst_n = 1'b1;
    hold(20);
    chk("bcd_after_rst", 32'(bcd), 32'h000);
    value = 8'd99;
    hold(30);

    for (int i = 0; i < 300; i++) begin
      value = 8'($urandom);
      if ($urandom_range(0, 7) == 0) hex_mode = 1'($urandom);
      if ($urandom_range(0, 7) == 0) blank_zero = 1'($urandom);
      hold($urandom_range(1, 14));
    end
    hold(40);

    tests++;
    if (cq.size() != 0) begin
      fails++;
      $display("FAIL pending: %0d conversions never completed, want 0",
               cq.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
